// File: rtl/ascon_perm_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ascon_perm_ctrl
// Purpose  : Iterative round controller for the Ascon-p permutation. It holds
//            the 320-bit state and steps it through an external
//            single-round stage once per clock. It then presents the result
//            with a valid/ready handshake.
// Ports    : clk_i, rst_i             - clock, synchronous active-high reset
//            start_i, rounds_i        - start request and round count (1..MAX)
//            x0_i..x4_i               - input state, sampled on accepted start
//            ready_o, err_o           - idle indicator, illegal-rounds pulse
//            rnd_x0_o..rnd_x4_o       - state presented to the round stage
//            rnd_cnt_o                - round-constant index for that stage
//            rnd_x0_i..rnd_x4_i       - one-round result from the stage
//            valid_o, ready_i         - result handshake
//            x0_o..x4_o               - permuted state words
// Revision : 1.0 - initial release
// ============================================================================
module ascon_perm_ctrl #(
  // Must not exceed 12: the start index is computed as 12 - rounds_i.
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        ready_o,
  output logic        err_o,
  output logic [63:0] rnd_x0_o,
  output logic [63:0] rnd_x1_o,
  output logic [63:0] rnd_x2_o,
  output logic [63:0] rnd_x3_o,
  output logic [63:0] rnd_x4_o,
  output logic [3:0]  rnd_cnt_o,
  input  logic [63:0] rnd_x0_i,
  input  logic [63:0] rnd_x1_i,
  input  logic [63:0] rnd_x2_i,
  input  logic [63:0] rnd_x3_i,
  input  logic [63:0] rnd_x4_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  localparam logic [3:0] C_LAST_RND  = 4'd11;
  localparam logic [3:0] C_TOTAL_RND = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [4:0][63:0]   x_q, x_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               rounds_ok;

  assign rounds_ok = (rounds_i != 4'd0) && ({28'd0, rounds_i} <= MAX_ROUNDS);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rounds_ok) begin
            x_d     = {x4_i, x3_i, x2_i, x1_i, x0_i};
            // Shorter permutations use the tail of the 12 round constants.
            cnt_d   = C_TOTAL_RND - rounds_i;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        x_d = {rnd_x4_i, rnd_x3_i, rnd_x2_i, rnd_x1_i, rnd_x0_i};
        // Index 11 is the final round; the counter parks there, never wraps.
        if (cnt_q == C_LAST_RND) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags come from the next state so they are plain flops.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign rnd_cnt_o = cnt_q;

  assign rnd_x0_o = x_q[0];
  assign rnd_x1_o = x_q[1];
  assign rnd_x2_o = x_q[2];
  assign rnd_x3_o = x_q[3];
  assign rnd_x4_o = x_q[4];

  assign x0_o = x_q[0];
  assign x1_o = x_q[1];
  assign x2_o = x_q[2];
  assign x3_o = x_q[3];
  assign x4_o = x_q[4];

endmodule
`default_nettype wire
